// File: rtl/pool_engine.sv
// pool_engine: max-pool sequencer reading pool-buffer windows and writing signed maxima; optional POOL_RELU_EN clamps to >= 0.
module pool_engine #(
  parameter int DW = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      state,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [5:0]      rd_y,
  output logic [5:0]      rd_x,
  output logic [5:0]      rd_c,
  output logic            rd_updown,
  input  logic [2*DW-1:0] rd_data,
  output logic            wr_en,
  output logic [5:0]      wr_y,
  output logic [5:0]      wr_x,
  output logic [5:0]      wr_c,
  output logic [DW-1:0]   wr_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;
  fsm_t fsm, fsm_nx;
  logic [3:0] layer;
  logic [5:0] oy, ox, oc;
  logic py, px, ud;
  logic p_valid, p_first, p_last;
  logic [5:0] p_y, p_x, p_c;
  logic signed [DW-1:0] acc, lo, hi, pair, m, wr_val;
  logic [5:0] dim_max, ch_max;
  logic pool3, legal, abort, win_first, win_last, x_last, y_last, c_last, rd_last, final_wr;
  always_comb begin
    pool3     = layer == 4'b0111;
    dim_max   = layer == 4'b0011 ? 6'd15 : layer == 4'b0101 ? 6'd7 : 6'd1;
    ch_max    = layer == 4'b0011 ? 6'd15 : layer == 4'b0101 ? 6'd31 : 6'd63;
    legal     = state inside {4'b0011, 4'b0101, 4'b0111};
    abort     = fsm != IDLE && state != layer;
    win_first = !ud && !px && !py;
    win_last  = ud && (!pool3 || (px && py));
    x_last    = ox == dim_max;
    y_last    = oy == dim_max;
    c_last    = oc == ch_max;
    rd_last   = win_last && x_last && y_last && c_last;
    final_wr  = fsm == DRAIN && wr_en && !p_valid;
    lo        = rd_data[DW-1:0];
    hi        = rd_data[2*DW-1:DW];
    pair      = lo > hi ? lo : hi;
    m         = p_first ? pair : (acc > pair ? acc : pair);
  end
`ifdef POOL_RELU_EN
  assign wr_val = m[DW-1] ? '0 : m;
`else
  assign wr_val = m;
`endif
  assign busy      = fsm != IDLE;
  assign rd_en     = fsm == RUN;
  assign rd_updown = ud;
  assign rd_y      = pool3 ? {oy[4:0], py} : oy;
  assign rd_x      = pool3 ? {ox[4:0], px} : ox;
  assign rd_c      = oc;
  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      IDLE:    fsm_nx = start && legal && !done ? RUN : IDLE;
      RUN:     fsm_nx = rd_last ? DRAIN : RUN;
      DRAIN:   fsm_nx = final_wr ? IDLE : DRAIN;
      default: fsm_nx = IDLE;
    endcase
    if (abort) fsm_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fsm <= IDLE;
    else fsm <= fsm_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer <= '0;
      {oy, ox, oc, py, px, ud} <= '0;
    end else begin
      if (fsm == IDLE && fsm_nx == RUN) layer <= state;
      if (abort || fsm != RUN) begin
        {oy, ox, oc, py, px, ud} <= '0;
      end else begin
        // ud innermost, then px/py (POOL3 only), then x, y, c; full wrap ends RUN
        ud <= !ud;
        if (ud && pool3) px <= !px;
        if (ud && pool3 && px) py <= !py;
        if (win_last) ox <= x_last ? 6'd0 : ox + 6'd1;
        if (win_last && x_last) oy <= y_last ? 6'd0 : oy + 6'd1;
        if (win_last && x_last && y_last) oc <= c_last ? 6'd0 : oc + 6'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {p_valid, p_first, p_last, wr_en, done} <= '0;
      {p_y, p_x, p_c, wr_y, wr_x, wr_c} <= '0;
      acc     <= '0;
      wr_data <= '0;
    end else if (abort) begin
      {p_valid, wr_en, done} <= '0;
    end else begin
      // read metadata delayed one cycle to line up with rd_data
      p_valid <= rd_en;
      p_first <= win_first;
      p_last  <= win_last;
      p_y     <= oy;
      p_x     <= ox;
      p_c     <= oc;
      wr_en   <= p_valid && p_last;
      done    <= final_wr;
      if (p_valid) acc <= m;
      if (p_valid && p_last) begin
        wr_data <= wr_val;
        wr_y    <= p_y;
        wr_x    <= p_x;
        wr_c    <= p_c;
      end
    end
  end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed bench for pool_engine with a pool-buffer pattern model and write/read monitors.
module tb_pool_engine;
  localparam int DW = 22;
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] state = 4'b0000;
  logic busy, done, rd_en, rd_updown, wr_en;
  logic [5:0] rd_y, rd_x, rd_c, wr_y, wr_x, wr_c;
  logic [2*DW-1:0] rd_data = '0;
  logic [DW-1:0] wr_data;
  int checks = 0, errors = 0;
  int mode = 0, dim = 16, nw = 2;
  int cyc = 0, n_rd, n_wr, n_done, n_bad, n_rdbad, n_wrbad, max_c;
  int first_rd, last_rd, first_wr, last_wr, done_cyc;
  logic [DW-1:0] first_val;
  pool_engine #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_y(rd_y), .rd_x(rd_x), .rd_c(rd_c), .rd_updown(rd_updown), .rd_data(rd_data),
    .wr_en(wr_en), .wr_y(wr_y), .wr_x(wr_x), .wr_c(wr_c), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  function automatic logic [2*DW-1:0] pat(input logic [5:0] y, input logic [5:0] x, input logic u);
    case (mode)
      0: pat = {DW'(2 * int'(x) + 1), DW'(2 * int'(x))};
      1: pat = u ? {DW'(7), DW'(2)} : {DW'(5), DW'(-3)};
      2: pat = (y[0] && x[0] && u) ? {DW'(-20), DW'(100)} : {DW'(-20), DW'(-20)};
      default: pat = {DW'(-5), DW'(-5)};
    endcase
  endfunction
  function automatic logic [DW-1:0] exp_wr(input logic [5:0] x);
    case (mode)
      0: exp_wr = DW'(2 * int'(x) + 1);
      1: exp_wr = DW'(7);
      2: exp_wr = DW'(100);
`ifdef POOL_RELU_EN
      default: exp_wr = '0;
`else
      default: exp_wr = 22'h3FFFFB;
`endif
    endcase
  endfunction
  always @(posedge clk) rd_data <= rd_en ? pat(rd_y, rd_x, rd_updown) : '0;
  always @(negedge clk) begin
    int s, w, ox, oy, oc, ey, ex;
    cyc++;
    if (rd_en) begin
      s = n_rd % nw; w = n_rd / nw;
      ox = w % dim; oy = (w / dim) % dim; oc = w / (dim * dim);
      ey = nw == 8 ? 2 * oy + (s / 4) : oy;
      ex = nw == 8 ? 2 * ox + ((s / 2) % 2) : ox;
      if (rd_y !== 6'(ey) || rd_x !== 6'(ex) || rd_c !== 6'(oc) || rd_updown !== 1'(s % 2)) n_rdbad++;
      if (n_rd == 0) first_rd = cyc;
      last_rd = cyc;
      n_rd++;
    end
    if (wr_en) begin
      ox = n_wr % dim; oy = (n_wr / dim) % dim; oc = n_wr / (dim * dim);
      if (wr_y !== 6'(oy) || wr_x !== 6'(ox) || wr_c !== 6'(oc)) n_wrbad++;
      if (wr_data !== exp_wr(wr_x)) n_bad++;
      if (n_wr == 0) begin first_wr = cyc; first_val = wr_data; end
      if (int'(wr_c) > max_c) max_c = int'(wr_c);
      last_wr = cyc;
      n_wr++;
    end
    if (done) begin n_done++; done_cyc = cyc; end
  end
  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_done = 0; n_bad = 0; n_rdbad = 0; n_wrbad = 0; max_c = 0;
    first_rd = 0; last_rd = 0; first_wr = 0; last_wr = 0; done_cyc = 0;
  endtask
  task automatic kick(input logic [3:0] code, input int md, input int d, input int n);
    @(negedge clk);
    clear_mon();
    mode = md; dim = d; nw = n; state = code; start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++; if (rd_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_accept rd_en=%b busy=%b want 1 1", rd_en, busy); end
  endtask
  task automatic run_layer(input string nm, input logic [3:0] code, input int md, input int d, input int n, input int rds, input int wrs);
    bit seen = 0;
    kick(code, md, d, n);
    for (int i = 0; i < 12000 && !seen; i++) begin @(negedge clk); seen = done; end
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout no done within budget", nm); end
    repeat (2) @(negedge clk);
    checks++; if (n_rd !== rds) begin errors++; $display("FAIL %s_reads got %0d want %0d", nm, n_rd, rds); end
    checks++; if (n_wr !== wrs) begin errors++; $display("FAIL %s_writes got %0d want %0d", nm, n_wr, wrs); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL %s_wr_data bad=%0d want 0", nm, n_bad); end
    checks++; if (n_rdbad !== 0) begin errors++; $display("FAIL %s_rd_coords bad=%0d want 0", nm, n_rdbad); end
    checks++; if (n_wrbad !== 0) begin errors++; $display("FAIL %s_wr_coords bad=%0d want 0", nm, n_wrbad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", nm, n_done); end
    checks++; if (last_rd - first_rd + 1 !== n_rd) begin errors++; $display("FAIL %s_read_bubbles span %0d want %0d", nm, last_rd - first_rd + 1, n_rd); end
    checks++; if (first_wr - first_rd !== n + 1) begin errors++; $display("FAIL %s_wr_latency got %0d want %0d", nm, first_wr - first_rd, n + 1); end
    checks++; if (done_cyc - last_wr !== 1) begin errors++; $display("FAIL %s_done_after_wr got %0d want 1", nm, done_cyc - last_wr); end
    checks++; if (done_cyc - last_rd !== 3) begin errors++; $display("FAIL %s_done_after_rd got %0d want 3", nm, done_cyc - last_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b want 0", nm, busy); end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, rd_updown, rd_y, rd_x, rd_c, wr_y, wr_x, wr_c, wr_data} !== '0) begin
      errors++; $display("FAIL reset_outputs busy=%b done=%b rd_en=%b wr_en=%b wr_data=%h want all 0", busy, done, rd_en, wr_en, wr_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_pool1_ramp();
    run_layer("pool1", 4'b0011, 0, 16, 2, 8192, 4096);
    checks++; if (first_val !== 22'd1) begin errors++; $display("FAIL pool1_first_write got %0d want 1", first_val); end
  endtask
  task automatic test_pool2_mixed();
    run_layer("pool2", 4'b0101, 1, 8, 2, 4096, 2048);
    checks++; if (max_c !== 31) begin errors++; $display("FAIL pool2_wr_c_span got %0d want 31", max_c); end
  endtask
  task automatic test_pool3_window();
    run_layer("pool3", 4'b0111, 2, 2, 8, 2048, 256);
  endtask
  task automatic test_all_negative();
    run_layer("neg", 4'b0111, 3, 2, 8, 2048, 256);
  endtask
  task automatic test_abort();
    kick(4'b0011, 0, 16, 2);
    repeat (100) @(negedge clk);
    state = 4'b0010;
    @(negedge clk);
    checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_drop rd_en=%b wr_en=%b busy=%b want 0 0 0", rd_en, wr_en, busy); end
    repeat (10) @(negedge clk);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done); end
    run_layer("rerun", 4'b0011, 0, 16, 2, 8192, 4096);
  endtask
  task automatic test_reset_mid();
    kick(4'b0101, 1, 8, 2);
    repeat (50) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, rd_updown, rd_y, rd_x, rd_c, wr_y, wr_x, wr_c, wr_data} !== '0) begin
      errors++; $display("FAIL reset_mid busy=%b rd_en=%b wr_en=%b rd_c=%0d wr_data=%h want all 0", busy, rd_en, wr_en, rd_c, wr_data);
    end
    @(negedge clk);
    rst_n = 1;
    state = 4'b0010; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL illegal_start busy=%b rd_en=%b want 0 0", busy, rd_en); end
  endtask
  initial begin
    clear_mon();
    test_reset();
    test_pool1_ramp();
    test_pool2_mixed();
    test_pool3_window();
    test_all_negative();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_engine.md
# pool_engine

Max-pool sequencer between the two feature buffers. It reads pairs of conv outputs from `feat_buf_pool` (2 × 22-bit words per read, up/down row select) and reduces each window to a signed maximum. It then writes the pooled map into `feat_buf_conv` for the next conv layer, or into the dense input during POOL3. It runs once per pool layer, started by the top-level controller while the global `state` holds POOL1, POOL2 or POOL3.

## Interface
Parameters:
- `DW`, 22, feature word width (matches `DATSIZE`)

Ports:
- `clk`  in  1  system clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `state`  in  4  global layer state: 4'b0011 POOL1, 4'b0101 POOL2, 4'b0111 POOL3
- `start`  in  1  one-cycle start request
- `busy`  out  1  high from accepted start until the done pulse
- `done`  out  1  one-cycle completion pulse
- `rd_en`  out  1  pool-buffer read enable
- `rd_y`, `rd_x`, `rd_c`  out  6 each  pooled-grid read coordinates
- `rd_updown`  out  1  0 = upper row, 1 = lower row
- `rd_data`  in  2·DW  bits [DW-1:0] = even column, [2DW-1:DW] = odd column; valid 1 cycle after `rd_en`
- `wr_en`  out  1  conv-buffer write enable
- `wr_y`, `wr_x`, `wr_c`  out  6 each  write coordinates
- `wr_data`  out  DW  pooled signed value

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN:
  - On `start` with `state` ∈ {0011, 0101, 0111}.
  - The layer code is latched at that point.
  - `start` in any other state, or while busy, is ignored.
- Layer geometry (out = pooled output grid; loop order c outer, y, x inner):
  - POOL1: 16×16×16 out. Per output, read (y,x,c) with updown 0, then updown 1.
  - POOL2: 8×8×32 out. Same 2-read pattern.
  - POOL3: 2×2×64 out, 4×4 window:
    - Per output (oy, ox, c), sub-loop py∈{0,1}, px∈{0,1}.
    - Each sub-step reads (2oy+py, 2ox+px, c) with updown 0, then updown 1.
    - 8 reads per output.
- Reduction:
  - Signed max over both halves of every `rd_data` in the window.
  - The accumulator is seeded with the first word of the window, never 0.
  - Ties keep either value; the results are identical.
- RUN → DRAIN after the last read is issued.
- DRAIN → IDLE when the final write completes. `done` pulses in the cycle after the last `wr_en`.
- Abort:
  - If `state` differs from the latched code while busy, go to IDLE next cycle.
  - Drop `rd_en`/`wr_en` at once, clear the counters, no `done`.
- Reset mid-operation: all outputs go to 0 immediately and the FSM enters IDLE.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` = 0. All coordinates, `rd_updown` and `wr_data` = 0.
- `rd_en` is registered, first asserted in the cycle after `start` is accepted.
- `rd_en` stays continuously high through RUN: one read per cycle, no bubbles.
- Window of N reads (N = 2 or 8):
  - The first read is issued at cycle k.
  - Its data arrives at k+1; the last arrives at k+N.
  - Registered `wr_en`, coordinates and `wr_data` appear at k+N+1.
- Throughput: POOL1/2 one write per 2 cycles; POOL3 one write per 8 cycles.
- Total read cycles: POOL1 8192, POOL2 4096, POOL3 2048. Writes: 4096, 2048, 256.
- `done` arrives 3 cycles after the last read issue for POOL1/2, and 3 cycles after it for POOL3 as well (last read k+N-1).
- `busy` falls with `done`. A new `start` is accepted from the cycle after `done`.
- Coordinate counters wrap to 0 at each loop boundary. The outermost wrap ends RUN.

## Configuration
- `POOL_RELU_EN`:
  - Defined: `wr_data` = max(window, 0); negative maxima are written as 0.
  - Undefined: `wr_data` = raw signed window max.
  - Read and write timing is identical in both builds.

## Test plan
- POOL1 with `rd_data` = {x·2+1, x·2} ramp:
  - Expect 4096 writes; write (0,0,0) = 1; `done` after write 4096.
  - Read cycles = 8192.
- POOL2 with up word {5, -3}, down word {7, 2}: every `wr_data` = 7; 2048 writes; wr_c spans 0..31.
- POOL3 window with one value 100 at px=1, py=1 down row, others -20: `wr_data` = 100; 256 writes; rd pattern has 8 reads per output.
- All inputs -5:
  - Without `POOL_RELU_EN`, `wr_data` = -5 (0x3FFFFB).
  - With it, `wr_data` = 0.
- `state` changed to 4'b0010 mid-POOL1: `rd_en`/`wr_en` low next cycle, no `done`; a new `start` in POOL1 runs cleanly.
- `rst_n` low during POOL2: all outputs 0 asynchronously; `start` while `state` = 4'b0010 is ignored (`busy` stays 0).
